// File: rtl/valu_logic_arb.sv
// valu_logic_arb: two-port round-robin arbiter/router for the vector logic unit; `define VALU_ARB_TAGCHK_EN adds the sticky tag/address check on err
module valu_logic_arb #(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH  = 32,
  parameter int OPSEL_WIDTH     = 2,
  parameter int ALU_LAT         = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_enable,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [REQ_ADDR_WIDTH-1:0]  req0_addr,
  input  logic [REQ_DATA_WIDTH-1:0]  req0_vec0,
  input  logic [REQ_DATA_WIDTH-1:0]  req0_vec1,
  input  logic [OPSEL_WIDTH-1:0]     req0_opSel,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [REQ_ADDR_WIDTH-1:0]  req1_addr,
  input  logic [REQ_DATA_WIDTH-1:0]  req1_vec0,
  input  logic [REQ_DATA_WIDTH-1:0]  req1_vec1,
  input  logic [OPSEL_WIDTH-1:0]     req1_opSel,
  output logic                       alu_in_valid,
  output logic [REQ_ADDR_WIDTH-1:0]  alu_in_addr,
  output logic [REQ_DATA_WIDTH-1:0]  alu_in_vec0,
  output logic [REQ_DATA_WIDTH-1:0]  alu_in_vec1,
  output logic [OPSEL_WIDTH-1:0]     alu_in_opSel,
  input  logic                       alu_out_valid,
  input  logic [RESP_DATA_WIDTH-1:0] alu_out_vec,
  input  logic [REQ_ADDR_WIDTH-1:0]  alu_out_addr,
  output logic                       resp0_valid,
  output logic [RESP_DATA_WIDTH-1:0] resp0_vec,
  output logic [REQ_ADDR_WIDTH-1:0]  resp0_addr,
  output logic                       resp1_valid,
  output logic [RESP_DATA_WIDTH-1:0] resp1_vec,
  output logic [REQ_ADDR_WIDTH-1:0]  resp1_addr,
  output logic                       busy,
  output logic                       err
);
  logic ptr, own, g0, g1, hit0, hit1;
  logic [ALU_LAT-1:0] tag_v, tag_o;
  always_comb begin
    g0   = rst & cfg_enable & req0_valid & (~req1_valid | ptr);
    g1   = rst & cfg_enable & req1_valid & (~req0_valid | ~ptr);
    hit0 = alu_out_valid & tag_v[ALU_LAT-1] & ~tag_o[ALU_LAT-1];
    hit1 = alu_out_valid & tag_v[ALU_LAT-1] & tag_o[ALU_LAT-1];
  end
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign busy = alu_in_valid | (|tag_v) | resp0_valid | resp1_valid;
  // ptr holds the last-granted requester; resetting to 1 lets requester 0 win first
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      alu_in_valid <= 1'b0;
      alu_in_addr  <= '0;
      alu_in_vec0  <= '0;
      alu_in_vec1  <= '0;
      alu_in_opSel <= '0;
      own          <= 1'b0;
      ptr          <= 1'b1;
    end else begin
      alu_in_valid <= g0 | g1;
      alu_in_addr  <= g0 ? req0_addr  : g1 ? req1_addr  : '0;
      alu_in_vec0  <= g0 ? req0_vec0  : g1 ? req1_vec0  : '0;
      alu_in_vec1  <= g0 ? req0_vec1  : g1 ? req1_vec1  : '0;
      alu_in_opSel <= g0 ? req0_opSel : g1 ? req1_opSel : '0;
      own          <= g1;
      ptr          <= (g0 | g1) ? g1 : ptr;
    end
  // owner tags ride alongside the unit so the last entry lines up with alu_out_valid
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v[0] <= alu_in_valid;
      tag_o[0] <= own;
      for (int i = 1; i < ALU_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
      end
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      resp0_valid <= 1'b0;
      resp0_vec   <= '0;
      resp0_addr  <= '0;
      resp1_valid <= 1'b0;
      resp1_vec   <= '0;
      resp1_addr  <= '0;
    end else begin
      resp0_valid <= hit0;
      resp0_vec   <= hit0 ? alu_out_vec  : '0;
      resp0_addr  <= hit0 ? alu_out_addr : '0;
      resp1_valid <= hit1;
      resp1_vec   <= hit1 ? alu_out_vec  : '0;
      resp1_addr  <= hit1 ? alu_out_addr : '0;
    end
`ifdef VALU_ARB_TAGCHK_EN
  logic [REQ_ADDR_WIDTH-1:0] tag_a [ALU_LAT];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < ALU_LAT; i++) tag_a[i] <= '0;
      err <= 1'b0;
    end else begin
      tag_a[0] <= alu_in_addr;
      for (int i = 1; i < ALU_LAT; i++) tag_a[i] <= tag_a[i-1];
      err <= err | (alu_out_valid ^ tag_v[ALU_LAT-1])
                 | (alu_out_valid & tag_v[ALU_LAT-1] & (alu_out_addr != tag_a[ALU_LAT-1]));
    end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_valu_logic_arb.sv
// tb_valu_logic_arb: scoreboard bench for valu_logic_arb with a 6-stage logic-unit model
module tb_valu_logic_arb;
  localparam int LAT = 6;
  logic clk = 1'b0, rst = 1'b1, cfg_enable = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic [63:0] req0_vec0 = '0, req0_vec1 = '0, req1_vec0 = '0, req1_vec1 = '0;
  logic [1:0]  req0_opSel = '0, req1_opSel = '0;
  logic alu_in_valid, alu_out_valid, resp0_valid, resp1_valid, busy, err;
  logic [31:0] alu_in_addr, alu_out_addr, resp0_addr, resp1_addr;
  logic [63:0] alu_in_vec0, alu_in_vec1, alu_out_vec, resp0_vec, resp1_vec;
  logic [1:0]  alu_in_opSel;

  valu_logic_arb dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_vec0(req0_vec0), .req0_vec1(req0_vec1), .req0_opSel(req0_opSel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_vec0(req1_vec0), .req1_vec1(req1_vec1), .req1_opSel(req1_opSel),
    .alu_in_valid(alu_in_valid), .alu_in_addr(alu_in_addr), .alu_in_vec0(alu_in_vec0),
    .alu_in_vec1(alu_in_vec1), .alu_in_opSel(alu_in_opSel),
    .alu_out_valid(alu_out_valid), .alu_out_vec(alu_out_vec), .alu_out_addr(alu_out_addr),
    .resp0_valid(resp0_valid), .resp0_vec(resp0_vec), .resp0_addr(resp0_addr),
    .resp1_valid(resp1_valid), .resp1_vec(resp1_vec), .resp1_addr(resp1_addr),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [31:0] addr; logic [63:0] a; logic [63:0] b; logic [1:0] sel; logic [63:0] res;} op_t;
  typedef struct {logic [31:0] addr; logic [63:0] vec; int cyc;} rsp_t;
  typedef struct {op_t o; int cyc;} iss_t;
  rsp_t q0[$], q1[$];
  iss_t iq[$];
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // logic unit model: not reset, so results in flight keep leaving after a DUT reset
  logic [LAT-1:0] u_v = '0;
  logic [31:0] u_a [LAT];
  logic [63:0] u_r [LAT];
  bit corrupt = 0;
  function automatic logic [63:0] unit_op(input logic [1:0] s, input logic [63:0] a, input logic [63:0] b);
    return s == 2'b01 ? a & b : s == 2'b10 ? a | b : s == 2'b11 ? a ^ b : 64'h0;
  endfunction
  always @(posedge clk) begin
    u_v[0] <= alu_in_valid;
    u_a[0] <= (corrupt && alu_in_addr == 32'h10) ? 32'h20 : alu_in_addr;
    u_r[0] <= unit_op(alu_in_opSel, alu_in_vec0, alu_in_vec1);
    for (int i = 1; i < LAT; i++) begin
      u_v[i] <= u_v[i-1];
      u_a[i] <= u_a[i-1];
      u_r[i] <= u_r[i-1];
    end
  end
  assign alu_out_valid = u_v[LAT-1];
  assign alu_out_addr  = u_a[LAT-1];
  assign alu_out_vec   = u_r[LAT-1];

  task automatic mon_resp(input int p, input logic v, input logic [31:0] a, input logic [63:0] d);
    rsp_t e;
    int n;
    n = p ? q1.size() : q0.size();
    if (v) begin
      if (n == 0) chk($sformatf("resp%0d_spurious", p), 1, 0);
      else begin
        if (p) e = q1.pop_front(); else e = q0.pop_front();
        chk($sformatf("resp%0d_cycle", p), cyc, e.cyc);
        chk($sformatf("resp%0d_addr", p), a, e.addr);
        chk($sformatf("resp%0d_vec", p), d, e.vec);
      end
    end else begin
      chk($sformatf("resp%0d_idle_zero", p), |{a, d}, 0);
      if (n > 0) begin
        e = p ? q1[0] : q0[0];
        if (e.cyc <= cyc) begin
          chk($sformatf("resp%0d_missing", p), 0, 1);
          if (p) void'(q1.pop_front()); else void'(q0.pop_front());
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      q0.delete(); q1.delete(); iq.delete();
    end else begin
      if (alu_in_valid) begin
        if (iq.size() == 0) chk("issue_spurious", 1, 0);
        else begin
          iss_t e;
          e = iq.pop_front();
          chk("issue_cycle", cyc, e.cyc);
          chk("issue_addr", alu_in_addr, e.o.addr);
          chk("issue_vec0", alu_in_vec0, e.o.a);
          chk("issue_vec1", alu_in_vec1, e.o.b);
          chk("issue_opsel", alu_in_opSel, e.o.sel);
        end
      end else begin
        chk("issue_idle_zero", |{alu_in_addr, alu_in_vec0, alu_in_vec1, alu_in_opSel}, 0);
        if (iq.size() > 0 && iq[0].cyc <= cyc) begin
          chk("issue_missing", 0, 1);
          void'(iq.pop_front());
        end
      end
      mon_resp(0, resp0_valid, resp0_addr, resp0_vec);
      mon_resp(1, resp1_valid, resp1_addr, resp1_vec);
    end
  end

  op_t z = '{default: '0};
  op_t c0[4] = '{'{32'h100, 64'h00FF00FF, 64'h0F0F0F0F, 2'b11, 64'h0FF00FF0},
                 '{32'h104, 64'hF0, 64'h0F, 2'b10, 64'hFF},
                 '{32'h108, 64'hFFFF_0000_FFFF_0000, 64'h1234_5678_9ABC_DEF0, 2'b01, 64'h1234_0000_9ABC_0000},
                 '{32'h10C, 64'h1, 64'h1, 2'b01, 64'h1}};
  op_t c1[4] = '{'{32'h200, 64'hAAAA, 64'h5555, 2'b11, 64'hFFFF},
                 '{32'h204, 64'h1000, 64'h0001, 2'b10, 64'h1001},
                 '{32'h208, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 2'b11, 64'h7FFF_FFFF_FFFF_FFFE},
                 '{32'h20C, 64'h1, 64'h1, 2'b01, 64'h1}};
  op_t e_ops[4] = '{'{32'h40, 64'h1, 64'h10, 2'b10, 64'h11},
                    '{32'h44, 64'h2, 64'h10, 2'b10, 64'h12},
                    '{32'h48, 64'h4, 64'h10, 2'b10, 64'h14},
                    '{32'h4C, 64'h8, 64'h10, 2'b10, 64'h18}};
  op_t single = '{32'h10, 64'hF0F0, 64'hFF00, 2'b01, 64'hF000};
  op_t zsel   = '{32'h300, 64'hDEAD, 64'hBEEF, 2'b00, 64'h0};
  op_t r_op   = '{32'h50, 64'hFF, 64'hFF, 2'b01, 64'hFF};
  op_t p0     = '{32'h60, 64'h3, 64'h5, 2'b11, 64'h6};
  op_t p1     = '{32'h64, 64'h3, 64'h5, 2'b01, 64'h1};

  task automatic step(input bit en, input bit v0, input op_t o0, input bit v1, input op_t o1, input int g);
    @(negedge clk);
    cfg_enable = en;
    req0_valid = v0; req0_addr = o0.addr; req0_vec0 = o0.a; req0_vec1 = o0.b; req0_opSel = o0.sel;
    req1_valid = v1; req1_addr = o1.addr; req1_vec0 = o1.a; req1_vec1 = o1.b; req1_opSel = o1.sel;
    #1;
    chk("req0_ready", req0_ready, g == 0);
    chk("req1_ready", req1_ready, g == 1);
    if (g == 0) begin
      iq.push_back('{o0, cyc + 1});
      q0.push_back('{o0.addr, o0.res, cyc + 8});
    end
    if (g == 1) begin
      iq.push_back('{o1, cyc + 1});
      q1.push_back('{o1.addr, o1.res, cyc + 8});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 0, z, 0, z, -1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_alu_in"}, {alu_in_valid, alu_in_addr, alu_in_vec0, alu_in_vec1, alu_in_opSel}, 0);
    chk({tag, "_resp_valid"}, {resp0_valid, resp1_valid}, 0);
    chk({tag, "_resp_data"}, |{resp0_vec, resp0_addr, resp1_vec, resp1_addr}, 0);
    chk({tag, "_busy_err"}, {busy, err}, 0);
    chk({tag, "_ready"}, {req0_ready, req1_ready}, 0);
  endtask

  initial begin
    int i0, i1, t0;
    #1 rst = 1'b0;
    req0_valid = 1'b1; cfg_enable = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("reset");
    req0_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    // contention: pointer starts at 1, so 0,1,0,1,0,1
    i0 = 0; i1 = 0;
    for (int k = 0; k < 6; k++) begin
      step(1, 1, c0[i0], 1, c1[i1], k % 2);
      if (k % 2 == 0) i0++; else i1++;
    end
    idle(10);
    step(1, 1, single, 0, z, 0);
    idle(10);
    step(1, 0, z, 1, zsel, 1);
    idle(10);
    // enable gating
    step(0, 1, e_ops[0], 0, z, -1);
    step(0, 1, e_ops[0], 0, z, -1);
    step(1, 1, e_ops[0], 0, z, 0);
    t0 = cyc;
    step(1, 1, e_ops[1], 0, z, 0);
    step(1, 1, e_ops[2], 0, z, 0);
    step(0, 1, e_ops[3], 0, z, -1);
    while (cyc < t0 + 10) step(0, 0, z, 0, z, -1);
    chk("busy_last_resp", busy, 1);
    step(0, 0, z, 0, z, -1);
    chk("busy_drained", busy, 0);
    idle(2);
    // reset mid-flight; last grant before reset is requester 0
    step(1, 0, z, 1, r_op, 1);
    step(1, 1, r_op, 0, z, 0);
    step(1, 0, z, 1, r_op, 1);
    step(1, 1, r_op, 0, z, 0);
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #1 chk_reset_outputs("midreset");
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    step(1, 1, p0, 1, p1, 0);
    step(1, 0, z, 1, p1, 1);
    idle(14);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    idle(2);
    // tag check: unit returns 0x20 for an op issued with 0x10
    corrupt = 1;
    step(1, 1, single, 0, z, 0);
    t0 = cyc;
    q0[q0.size()-1].addr = 32'h20;
    while (cyc < t0 + 7) step(1, 0, z, 0, z, -1);
    chk("err_before_resp", err, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, z, 0, z, -1);
`ifdef VALU_ARB_TAGCHK_EN
      chk("err_sticky", err, 1);
`else
      chk("err_tied_low", err, 0);
`endif
    end
    corrupt = 0;
    idle(12);
    chk("queues_empty", q0.size() + q1.size() + iq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/valu_logic_arb.md
Name: valu_logic_arb

Overview:
- Two-requester round-robin arbiter and response router for the shared 6-stage vector AND/OR/XOR logic unit.
- Accepts requests from two issue ports and issues at most one op per cycle to the unit.
- Tracks each in-flight op's owner in a tag pipeline matched to the unit latency, then steers each result back to the requester that issued it.

Parameters:
- REQ_DATA_WIDTH, 64, operand width.
- RESP_DATA_WIDTH, 64, result width.
- REQ_ADDR_WIDTH, 32, destination address width.
- OPSEL_WIDTH, 2, op select width (01=and, 10=or, 11=xor, 00=zero).
- ALU_LAT, 6, cycles from alu_in_valid to alu_out_valid; must be ≥1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- cfg_enable  input  1  grant enable; low blocks new grants, in-flight ops still drain.
- req0_valid  input  1  requester 0 op valid.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_addr  input  REQ_ADDR_WIDTH  destination address.
- req0_vec0, req0_vec1  input  REQ_DATA_WIDTH  operands.
- req0_opSel  input  OPSEL_WIDTH  op select.
- req1_*  same set as req0_* for requester 1.
- alu_in_valid  output  1  issue valid to unit.
- alu_in_addr  output  REQ_ADDR_WIDTH  address to unit.
- alu_in_vec0, alu_in_vec1  output  REQ_DATA_WIDTH  operands to unit.
- alu_in_opSel  output  OPSEL_WIDTH  op select to unit.
- alu_out_valid  input  1  unit result valid.
- alu_out_vec  input  RESP_DATA_WIDTH  unit result.
- alu_out_addr  input  REQ_ADDR_WIDTH  unit result address.
- resp0_valid, resp1_valid  output  1  result valid for requester.
- resp0_vec, resp1_vec  output  RESP_DATA_WIDTH  result.
- resp0_addr, resp1_addr  output  REQ_ADDR_WIDTH  result address.
- busy  output  1  any op issued or in flight.
- err  output  1  sticky tag-check error.

Behaviour:
- Reset (rst low, async):
  - All outputs 0, including alu_in_*, resp*_*, busy and err.
  - Tag pipeline cleared; priority pointer = 1, so requester 0 wins first.
- Grant (combinational, same cycle):
  - Requires cfg_enable=1.
  - Only one valid: that requester gets ready.
  - Both valid: the requester other than the last-granted one gets ready.
  - Pointer updates to the granted requester on each handshake (valid & ready); no handshake leaves it unchanged.
- At most one ready per cycle. ready never asserts without the matching valid.
- Issue register: on a handshake at cycle T, alu_in_* = the granted requester's fields during T+1 with alu_in_valid=1. Otherwise alu_in_valid=0 and all alu_in_* data fields = 0.
- opSel 00 is forwarded unchanged; the unit returns zero and the response is delivered normally.
- Tag pipeline:
  - ALU_LAT entries, each {valid, owner}.
  - Entry 0 loads {alu_in_valid, owner} every cycle and shifts each cycle.
  - The last entry aligns with alu_out_valid.
- Response: registered. At cycle T+1+ALU_LAT+1 (= T+8 at default), respN_valid=1 with alu_out_vec/addr for owner N. The other port's resp_valid=0 and its data fields hold 0.
- Throughput: one op per cycle sustained. Responses return in issue order, with no gaps beyond the issue gaps.
- No response backpressure: requesters must always sink responses.
- busy = alu_in_valid | any tag-entry valid | any resp valid.
- cfg_enable falling mid-stream: no new grants from that cycle; issued ops complete and busy falls after the last response.
- Reset mid-operation: all in-flight tags dropped. Results still leaving the unit after reset release are discarded, because their tags are invalid.

Optional Feature:
- Macro: VALU_ARB_TAGCHK_EN.
- With it defined:
  - err sets sticky, cleared only by reset, when alu_out_valid differs from the last tag entry's valid.
  - err also sets when alu_out_addr differs from the issued address, held in a parallel address pipeline.
  - The mismatched result is still routed by tag.
- Without it: no address pipeline, and err is tied 0.

Test Plan:
- Single op: req0 valid, addr=0x10, vec0=0xF0F0, vec1=0xFF00, opSel=01 at T -> req0_ready at T; alu_in_valid at T+1; resp0_valid at T+8 with vec=0xF000, addr=0x10; resp1_valid stays 0.
- Contention: req0 and req1 both valid continuously for 6 cycles -> grants 0,1,0,1,0,1; resp0 and resp1 alternate on consecutive cycles starting at T+8, with XOR/OR results correct per op.
- Enable gating: cfg_enable=0 with req0 valid -> req0_ready=0 and no alu_in_valid. cfg_enable drops after 3 back-to-back grants -> exactly 3 responses, then busy=0 at T+11.
- Reset mid-flight: 4 ops issued, rst low for 1 cycle at T+3 -> all outputs 0, no resp*_valid afterwards even though the unit model still emits results; pointer restored (req0 wins next contention).
- Tag check (VALU_ARB_TAGCHK_EN): unit model returns alu_out_addr=0x20 for an op issued with 0x10 -> err=1 from the response cycle onward until reset. Without the macro, err=0 throughout.
- opSel=00 from req1 with nonzero operands -> resp1_vec=0, resp1_valid=1 at T+8.
